// File: rtl/module_display_scan_ctrl.sv
// rtl/module_display_scan_ctrl.sv - seven-segment scan controller with frame-aligned word loading
module module_display_scan_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                  clk_10Mhz_i,
  input  logic                  reset_i,
  input  logic                  tick_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic                  blank_lz_i,
  output logic [N_DIGITS-1:0]   anodo_o,
  output logic [6:0]            catodo_o,
  output logic [2:0]            digit_idx_o
);

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

  localparam logic [N_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [2:0]          LAST_IDX = 3'(N_DIGITS-1);

  state_t                state_q;
  logic [4*N_DIGITS-1:0] disp_q;
  logic [4*N_DIGITS-1:0] pend_q;
  logic                  pend_full_q;
  logic [2:0]            idx_q;

  logic [3:0]            cur_nibble;
  logic                  upper_zero;
  logic                  suppress;
  logic                  accept;
  logic [N_DIGITS-1:0]   an_onehot;
  logic [6:0]            seg_code;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Select the current digit and detect whether it and every digit above it are zero
  always_comb begin
    cur_nibble = 4'h0;
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (3'(i) == idx_q) cur_nibble = disp_q[4*i +: 4];
      if ((3'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  assign suppress    = blank_lz_i && (idx_q != 3'd0) && upper_zero;
  assign accept      = load_valid_i && load_ready_o;
  assign an_onehot   = AN_ONE << idx_q;
  assign seg_code    = hex_decode(cur_nibble);
  assign digit_idx_o = idx_q;

  // Scan FSM, pending-word buffer and registered display outputs
  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      state_q      <= OFF;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      load_ready_o <= 1'b1;
      idx_q        <= 3'd0;
      anodo_o      <= AN_OFF;
      catodo_o     <= SEG_OFF;
    end else begin
      // ready is low whenever the buffer is full, so an accept never
      // coincides with the boundary transfer below
      if (accept) begin
        pend_q       <= data_i;
        pend_full_q  <= 1'b1;
        load_ready_o <= 1'b0;
      end
      case (state_q)
        OFF: begin
          anodo_o  <= AN_OFF;
          catodo_o <= SEG_OFF;
          if (tick_i) state_q <= BLANK;
        end
        BLANK: begin
          state_q <= DRIVE;
          if (suppress) begin
            anodo_o  <= AN_OFF;
            catodo_o <= SEG_OFF;
          end else begin
            anodo_o  <= ACTIVE_LOW ? ~an_onehot : an_onehot;
            catodo_o <= ACTIVE_LOW ? ~seg_code : seg_code;
          end
        end
        DRIVE: begin
          if (tick_i) begin
            state_q  <= BLANK;
            anodo_o  <= AN_OFF;
            catodo_o <= SEG_OFF;
            if (idx_q == LAST_IDX) begin
              idx_q <= 3'd0;
              // Frame boundary: swap in the pending word so a frame is never mixed
              if (pend_full_q) begin
                disp_q       <= pend_q;
                pend_full_q  <= 1'b0;
                load_ready_o <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q  <= OFF;
          anodo_o  <= AN_OFF;
          catodo_o <= SEG_OFF;
        end
      endcase
    end
  end

endmodule
